mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory (MEMSTAGE) between the CPU MEM stage and a DMA/loader port. It owns the MEM_WrEn / ALU_MEM_Addr / MEM_DataIn / MEM_DataOut connection, grants one requester at a time through a req/gnt handshake, and bounds each ownership to a configurable burst length. It also steers one-cycle-late read data back to the requester that issued the read.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_if.sv | 27 ++
 rtl/mem_arb_fsm.sv | 90 +++++++++
 rtl/mem_arbiter.sv | 84 ++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF    = 10;
   localparam int DATA_W_DEF    = 32;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_CPU = 2'd1,
      OWN_DMA = 2'd2
   } arb_state_t;

   typedef enum logic {
      CPU = 1'b0,
      DMA = 1'b1
   } owner_t;

   function automatic owner_t other_side(owner_t o);
      return (o == CPU) ? DMA : CPU;
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester-side req/gnt beat interface with read return
interface mem_arb_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, din,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, din,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/mem_arb_fsm.sv
// rtl/mem_arb_fsm.sv - ownership FSM, beat counter and tie-break (MEM_ARB_RR_EN selects round-robin)
module mem_arb_fsm
   import mem_arb_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic dma_req,
   output logic cpu_gnt,
   output logic dma_gnt
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          beat;
   logic          limit_hit;
   logic          tie_cpu;

   // Counter saturates so a lone owner can keep beating without wrapping.
   assign cnt_inc   = (cnt == MAX_CNT) ? cnt : cnt + CW'(1);
   assign limit_hit = (cnt_inc == MAX_CNT);
   assign beat      = ((state == OWN_CPU) && cpu_req) || ((state == OWN_DMA) && dma_req);

`ifdef MEM_ARB_RR_EN
   owner_t rr_ptr;

   // Pointer flips to the opposite of the owner whose tenure just ended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= CPU;
      end else if ((state != IDLE) && (state_nxt != state)) begin
         rr_ptr <= other_side((state == OWN_CPU) ? CPU : DMA);
      end
   end

   assign tie_cpu = (rr_ptr == CPU);
`else
   assign tie_cpu = 1'b1;
`endif

   // Next ownership: idle ties, voluntary release, and burst-limit handover.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu_req && (!dma_req || tie_cpu)) state_nxt = OWN_CPU;
            else if (dma_req)                     state_nxt = OWN_DMA;
         end
         OWN_CPU: begin
            if (cpu_req) begin
               if (limit_hit && dma_req) state_nxt = OWN_DMA;
            end else begin
               state_nxt = dma_req ? OWN_DMA : IDLE;
            end
         end
         OWN_DMA: begin
            if (dma_req) begin
               if (limit_hit && cpu_req) state_nxt = OWN_CPU;
            end else begin
               state_nxt = cpu_req ? OWN_CPU : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with grants registered alongside it; counter clears on any change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         cpu_gnt <= 1'b0;
         dma_gnt <= 1'b0;
      end else begin
         state   <= state_nxt;
         cpu_gnt <= (state_nxt == OWN_CPU);
         dma_gnt <= (state_nxt == OWN_DMA);
         if (state_nxt != state) cnt <= '0;
         else if (beat)          cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter for the shared data memory (MEM_ARB_RR_EN enables round-robin ties)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_arb_if.slave          cpu,
   mem_arb_if.slave          dma,
   output logic              MEM_WrEn,
   output logic [ADDR_W-1:0] ALU_MEM_Addr,
   output logic [DATA_W-1:0] MEM_DataIn,
   input  logic [DATA_W-1:0] MEM_DataOut
);

   logic              cpu_gnt;
   logic              dma_gnt;
   logic              cpu_beat;
   logic              dma_beat;
   logic              cpu_rv;
   logic              dma_rv;
   logic              rd_pend;
   owner_t            rd_tag;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] dma_hold;

   mem_arb_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .cpu_req (cpu.req),
      .dma_req (dma.req),
      .cpu_gnt (cpu_gnt),
      .dma_gnt (dma_gnt)
   );

   assign cpu.gnt  = cpu_gnt;
   assign dma.gnt  = dma_gnt;
   assign cpu_beat = cpu_gnt & cpu.req;
   assign dma_beat = dma_gnt & dma.req;

   // Memory bus follows the owner only while it is actually beating; otherwise all zero.
   always_comb begin
      MEM_WrEn     = 1'b0;
      ALU_MEM_Addr = '0;
      MEM_DataIn   = '0;
      if (cpu_beat) begin
         MEM_WrEn     = cpu.we;
         ALU_MEM_Addr = cpu.addr;
         MEM_DataIn   = cpu.din;
      end else if (dma_beat) begin
         MEM_WrEn     = dma.we;
         ALU_MEM_Addr = dma.addr;
         MEM_DataIn   = dma.din;
      end
   end

   assign cpu_rv = rd_pend && (rd_tag == CPU);
   assign dma_rv = rd_pend && (rd_tag == DMA);

   assign cpu.rvalid = cpu_rv;
   assign dma.rvalid = dma_rv;
   // Memory output is passed straight through in the return cycle and latched so it holds afterwards.
   assign cpu.rdata  = cpu_rv ? MEM_DataOut : cpu_hold;
   assign dma.rdata  = dma_rv ? MEM_DataOut : dma_hold;

   // Tag each read beat with its issuer and capture the returned word for that side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend  <= 1'b0;
         rd_tag   <= CPU;
         cpu_hold <= '0;
         dma_hold <= '0;
      end else begin
         rd_pend <= (cpu_beat && !cpu.we) || (dma_beat && !dma.we);
         if (cpu_beat || dma_beat) rd_tag <= cpu_beat ? CPU : DMA;
         if (cpu_rv) cpu_hold <= MEM_DataOut;
         if (dma_rv) dma_hold <= MEM_DataOut;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   always #5 clk = ~clk;

   mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
   mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu          (cpu_if),
      .dma          (dma_if),
      .MEM_WrEn     (mem_we),
      .ALU_MEM_Addr (mem_addr),
      .MEM_DataIn   (mem_din),
      .MEM_DataOut  (mem_dout)
   );

   // external single-port memory, one-cycle read latency
   logic [DW-1:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: owner 0=none 1=cpu 2=dma
   int            m_owner, m_beats, m_last, m_pend;
   logic [DW-1:0] m_pdata, m_hold_cpu, m_hold_dma;
   logic [DW-1:0] ref_mem [0:1023];

   task automatic m_reset();
      m_owner = 0; m_beats = 0; m_last = 2; m_pend = 0;
      m_pdata = '0; m_hold_cpu = '0; m_hold_dma = '0;
   endtask

   function automatic int tie_winner();
`ifdef MEM_ARB_RR_EN
      return (m_last == 1) ? 2 : 1;
`else
      return 1;
`endif
   endfunction

   task automatic m_step();
      bit            rq [1:2];
      bit            w;
      int            a, nxt, side;
      logic [DW-1:0] d;
      rq[1] = cpu_if.req; rq[2] = dma_if.req;
      if (m_pend == 1) m_hold_cpu = m_pdata;
      if (m_pend == 2) m_hold_dma = m_pdata;
      m_pend = 0;
      side = (m_owner != 0 && rq[m_owner]) ? m_owner : 0;
      if (side != 0) begin
         w = (side == 1) ? cpu_if.we : dma_if.we;
         a = int'((side == 1) ? cpu_if.addr : dma_if.addr);
         d = (side == 1) ? cpu_if.din : dma_if.din;
         if (w) ref_mem[a] = d;
         else begin m_pend = side; m_pdata = ref_mem[a]; end
      end
      nxt = m_owner;
      if (m_owner == 0) begin
         if (rq[1] && rq[2]) nxt = tie_winner();
         else if (rq[1])     nxt = 1;
         else if (rq[2])     nxt = 2;
      end else if (rq[m_owner]) begin
         m_beats = (m_beats + 1 > MB) ? MB : m_beats + 1;
         if (m_beats == MB && rq[3 - m_owner]) nxt = 3 - m_owner;
      end else begin
         nxt = rq[3 - m_owner] ? 3 - m_owner : 0;
      end
      if (nxt != m_owner) begin
         if (m_owner != 0) m_last = m_owner;
         m_beats = 0;
         m_owner = nxt;
      end
   endtask

   task automatic tick_check();
      bit cb, db;
      @(negedge clk);
      cb = (m_owner == 1) && cpu_if.req;
      db = (m_owner == 2) && dma_if.req;
      check("cpu_gnt", cpu_if.gnt, m_owner == 1);
      check("dma_gnt", dma_if.gnt, m_owner == 2);
      check("wren", mem_we, cb ? cpu_if.we : (db ? dma_if.we : 1'b0));
      check("addr", mem_addr, cb ? cpu_if.addr : (db ? dma_if.addr : '0));
      check("din", mem_din, cb ? cpu_if.din : (db ? dma_if.din : '0));
      check("cpu_rvalid", cpu_if.rvalid, m_pend == 1);
      check("dma_rvalid", dma_if.rvalid, m_pend == 2);
      check("cpu_rdata", cpu_if.rdata, (m_pend == 1) ? m_pdata : m_hold_cpu);
      check("dma_rdata", dma_if.rdata, (m_pend == 2) ? m_pdata : m_hold_dma);
   endtask

   task automatic tick_adv();
      @(posedge clk);
      if (rst_n) m_step();
      #1;
   endtask

   task automatic drv(input bit cr, input bit cw, input int ca, input int cd,
                      input bit dr, input bit dw, input int da, input int dd);
      cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca[AW-1:0]; cpu_if.din = cd;
      dma_if.req = dr; dma_if.we = dw; dma_if.addr = da[AW-1:0]; dma_if.din = dd;
   endtask

   task automatic cyc();
      tick_check();
      tick_adv();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      m_reset();
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // CPU write 5 to addr 0, then read it back
      drv(1, 1, 0, 5, 0, 0, 0, 0);
      cyc();
      tick_check();
      check("wr_beat_wren", mem_we, 1'b1);
      tick_adv();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick_check();
      check("rd_cpu_rvalid", cpu_if.rvalid, 1'b1);
      check("rd_cpu_rdata", cpu_if.rdata, 32'd5);
      check("rd_dma_rvalid", dma_if.rvalid, 1'b0);
      tick_adv();
      cyc();

      // both requesting continuously: 4 CPU beats, 4 DMA beats, CPU again
      drv(1, 1, 2, 11, 1, 1, 3, 22);
      for (int i = 0; i < 10; i++) begin
         tick_check();
         check("tie_cpu_gnt", cpu_if.gnt, (i != 0) && (((i - 1) / MB) % 2 == 0));
         check("tie_dma_gnt", dma_if.gnt, (i != 0) && (((i - 1) / MB) % 2 == 1));
         tick_adv();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();

      // lone CPU keeps ownership past the burst limit
      drv(1, 1, 4, 44, 0, 0, 0, 0);
      cyc();
      for (int i = 0; i < 10; i++) begin
         tick_check();
         check("lone_cpu_gnt", cpu_if.gnt, 1'b1);
         tick_adv();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();

      // DMA preloads addr 1 = 666, reads it on its last beat, CPU takes over
      drv(0, 0, 0, 0, 1, 1, 1, 666);
      cyc();
      cyc();
      drv(0, 0, 0, 0, 1, 1, 3, 33);
      cyc();
      cyc();
      drv(1, 0, 0, 0, 1, 0, 1, 0);
      cyc();
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      tick_check();
      check("il_cpu_gnt", cpu_if.gnt, 1'b1);
      check("il_dma_rvalid", dma_if.rvalid, 1'b1);
      check("il_dma_rdata", dma_if.rdata, 32'd666);
      check("il_cpu_rvalid", cpu_if.rvalid, 1'b0);
      tick_adv();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();

      // async reset during a DMA read beat
      drv(0, 0, 0, 0, 1, 0, 1, 0);
      cyc();
      #2;
      check("pre_rst_dma_gnt", dma_if.gnt, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_dma_gnt", dma_if.gnt, 1'b0);
      check("rst_dma_rvalid", dma_if.rvalid, 1'b0);
      check("rst_wren", mem_we, 1'b0);
      m_reset();
      drv(1, 0, 0, 0, 1, 0, 1, 0);
      tick_check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();
      tick_check();
      check("post_rst_tie_cpu", cpu_if.gnt, 1'b1);
      tick_adv();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();

      // request dropped in the grant cycle
      drv(1, 1, 7, 77, 0, 0, 0, 0);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick_check();
      check("drop_cpu_gnt", cpu_if.gnt, 1'b1);
      check("drop_wren", mem_we, 1'b0);
      tick_adv();
      tick_check();
      check("drop_released", cpu_if.gnt, 1'b0);
      tick_adv();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drv($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
             $urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
